alu_chain_ctrl: RTL and testbench
=================================

Name: alu_chain_ctrl

Overview:
- Multi-precision sequencer wrapped around the 12-bit ALU.
- Accepts one command for a 1..WORDS-word (up to 48-bit) ADD, SUB, SHL, SHR or ASR.
- Issues one ALU operation per cycle, word by word, and chains the K flag through the 5-bit flag vector {P,V,K,S,Z}.
- Sits between the execute stage and the ALU; returns the full-width result and the merged flags over a valid/ready handshake.

Parameters:
- WORDS, 4, maximum operand length in 12-bit words (1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  3  0=ADD, 1=SUB, 2=SHL, 3=SHR, 4=ASR, 5..7 see Behaviour.
- cmd_len  in  2  word count minus 1; values above WORDS-1 are clamped to WORDS-1.
- cmd_a  in  12*WORDS  operand A; the shifted value for shift ops.
- cmd_b  in  12*WORDS  operand B; ignored for shift ops.
- cmd_flg  in  5  incoming flags {P,V,K,S,Z}.
- alu_a  out  12  to ALU A.
- alu_b  out  12  to ALU B.
- alu_op  out  5  to ALU operation.
- alu_flg_in  out  5  to ALU flag input.
- alu_q  in  12  ALU result.
- alu_flg  in  5  ALU flag output.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_q  out  12*WORDS  result; words above cmd_len are 0.
- res_flg  out  5  merged flags.

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset enters IDLE from any state, including mid-RUN; the in-flight command is discarded.
- Reset values: cmd_ready=1, res_valid=0, res_q=0, res_flg=0, index=0.
- IDLE: cmd_ready=1. cmd_valid&cmd_ready latches cmd_a, cmd_b, cmd_op, n=cmd_len+1 and cmd_flg, then enters RUN.
- RUN: exactly n cycles; cmd_ready=0.
  - Step i selects word w. For ADD/SUB/SHL, w=i (low word first). For SHR/ASR, w=n-1-i (high word first).
  - alu_a = A word w; alu_b = B word w for ADD/SUB, A word w for shifts.
  - Step 0 opcodes: ADD=0x04, SUB=0x06, SHL=0x0C, SHR=0x0D, ASR=0x0F.
  - Steps 1..n-1 opcodes: ADK=0x05, SBK=0x07, RKL=0x0A, RKR=0x0B, RKR=0x0B.
  - alu_flg_in: cmd_flg at step 0; afterwards the flags registered from the previous step.
- Each RUN cycle registers:
  - alu_q into result word w;
  - alu_flg into the step-flag register;
  - zacc &= alu_flg[0], with zacc=1 at accept.
- Final flags:
  - K = last step's K.
  - S and V = flags from the step that processed word n-1: the last step for ADD/SUB/SHL, step 0 for SHR/ASR.
  - Z = zacc.
  - P = cmd_flg P.
- After step n-1, enter DONE. Latency: accept at edge k gives res_valid=1 from cycle k+n.
- DONE: res_valid=1; res_q and res_flg are held stable while res_ready=0. res_valid&res_ready returns to IDLE. The next command can be accepted one cycle later; there is no result/command overlap.
- Outside RUN: alu_op=0x00, alu_a=0, alu_b=0, alu_flg_in=0.
- Reserved ops 5..7 (and op 5 when the optional feature is off):
  - Run n cycles with alu_op=0x00 (MOV) and alu_b = A word w.
  - Result = cmd_a; res_flg = cmd_flg exactly.
- n=1 degenerates to a single ALU op; res_flg equals alu_flg except P.

Optional Feature:
- Macro ALU_CHAIN_CMP_EN.
- When defined, op 5 = CMP: sequenced as SUB/SBK, with res_flg computed as for SUB, but res_q = cmd_a (destination preserved).
- When undefined, op 5 is reserved (MOV behaviour above).

Test Plan:
- ADD n=2, a=0x000FFF, b=0x000001, flg=0 → after 2 cycles res_q=0x001000; K=0, Z=0, S=0, V=0; alu_op sequence 0x04,0x05.
- ADD n=4, a=0xFFFFFFFFFFFF, b=1 → exactly 4 RUN cycles; res_q=0; Z=1, K=1, S=0.
- SUB n=2, a=0x000000, b=0x000001 → res_q=0xFFFFFF; K=1, S=1, Z=0.
- SHR n=3, a=0x001000000 → res_q=0x000800000, K=0; word order high→low with ops 0x0D,0x0B,0x0B. ASR n=2, a=0x800001 → res_q=0xC00000, K=1, S=1.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid → res_q/res_flg stable, cmd_ready=0; res_ready=1 → IDLE next cycle, cmd_ready=1.
- Assert rst during RUN step 1 of an n=4 ADD → next cycle IDLE, res_valid=0, res_q=0, alu_op=0x00; a fresh command then completes correctly.

Source files
------------

// File: rtl/alu_chain_ctrl.sv
// alu_chain_ctrl: multi-precision sequencer in front of the 12-bit ALU.
// Runs ADD/SUB/SHL/SHR/ASR over 1..WORDS words, one ALU op per cycle,
// chaining the K flag word to word and merging the per-step flags.
// Optional feature macro: ALU_CHAIN_CMP_EN (op 5 becomes CMP).
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | one ALU step per cycle, n steps total
// DONE  | result and merged flags held until res_ready
module alu_chain_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [1:0]            cmd_len,
  input  logic [12*WORDS-1:0]   cmd_a,
  input  logic [12*WORDS-1:0]   cmd_b,
  input  logic [4:0]            cmd_flg,
  output logic [11:0]           alu_a,
  output logic [11:0]           alu_b,
  output logic [4:0]            alu_op,
  output logic [4:0]            alu_flg_in,
  input  logic [11:0]           alu_q,
  input  logic [4:0]            alu_flg,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [12*WORDS-1:0]   res_q,
  output logic [4:0]            res_flg
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd2;
  localparam logic [2:0] OP_SHR = 3'd3;
  localparam logic [2:0] OP_ASR = 3'd4;
  localparam logic [2:0] OP_CMP = 3'd5;

  localparam logic [1:0] LAST_MAX = 2'(WORDS - 1);

`ifdef ALU_CHAIN_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  state_t                  state_q;
  logic [WORDS-1:0][11:0]  a_q;
  logic [WORDS-1:0][11:0]  b_q;
  logic [WORDS-1:0][11:0]  res_word_q;
  logic [2:0]              op_q;
  logic [1:0]              last_q;
  logic [1:0]              idx_q;
  logic [4:0]              cflg_q;
  logic [4:0]              sflg_q;
  logic                    zacc_q;
  logic [1:0]              vs_q;       // {V,S} captured on the top-word step
  logic [4:0]              res_flg_q;
  logic                    cmd_ready_q;
  logic                    res_valid_q;

  logic [1:0]  last_d;
  logic [1:0]  word_sel;
  logic        is_cmp;
  logic        is_pass;
  logic        keep_a;
  logic        high_first;
  logic        first_step;
  logic        last_step;
  logic        top_word;
  logic [1:0]  vs_now;
  logic [4:0]  res_flg_d;

  assign cmd_ready = cmd_ready_q;
  assign res_valid = res_valid_q;
  assign res_q     = res_word_q;
  assign res_flg   = res_flg_q;

  // Decode the latched command and work out which word this step touches
  always_comb begin
    last_d     = (cmd_len > LAST_MAX) ? LAST_MAX : cmd_len;
    is_cmp     = CMP_EN && (op_q == OP_CMP);
    is_pass    = (op_q > OP_ASR) && !is_cmp;
    keep_a     = is_pass || is_cmp;
    high_first = (op_q == OP_SHR) || (op_q == OP_ASR);
    word_sel   = high_first ? (last_q - idx_q) : idx_q;
    first_step = (idx_q == 2'd0);
    last_step  = (idx_q == last_q);
    top_word   = (word_sel == last_q);
    vs_now     = top_word ? {alu_flg[3], alu_flg[1]} : vs_q;
    res_flg_d  = is_pass ? cflg_q
                         : {cflg_q[4], vs_now[1], alu_flg[2], vs_now[0], zacc_q & alu_flg[0]};
  end

  // ALU drive: idle values outside RUN, chained opcode/flags inside RUN
  always_comb begin
    alu_a      = 12'h000;
    alu_b      = 12'h000;
    alu_op     = 5'h00;
    alu_flg_in = 5'h00;
    if (state_q == S_RUN) begin
      alu_a      = a_q[word_sel];
      alu_flg_in = first_step ? cflg_q : sflg_q;
      if (op_q == OP_ADD) begin
        alu_b  = b_q[word_sel];
        alu_op = first_step ? 5'h04 : 5'h05;
      end else if (op_q == OP_SUB || is_cmp) begin
        alu_b  = b_q[word_sel];
        alu_op = first_step ? 5'h06 : 5'h07;
      end else if (op_q == OP_SHL) begin
        alu_b  = a_q[word_sel];
        alu_op = first_step ? 5'h0C : 5'h0A;
      end else if (op_q == OP_SHR) begin
        alu_b  = a_q[word_sel];
        alu_op = first_step ? 5'h0D : 5'h0B;
      end else if (op_q == OP_ASR) begin
        alu_b  = a_q[word_sel];
        alu_op = first_step ? 5'h0F : 5'h0B;
      end else begin
        alu_b  = a_q[word_sel];
        alu_op = 5'h00;
      end
    end
  end

  // Sequencer FSM with registered handshake, result and flag outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_word_q  <= '0;
      op_q        <= 3'd0;
      last_q      <= 2'd0;
      idx_q       <= 2'd0;
      cflg_q      <= 5'd0;
      sflg_q      <= 5'd0;
      zacc_q      <= 1'b1;
      vs_q        <= 2'd0;
      res_flg_q   <= 5'd0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            a_q         <= cmd_a;
            b_q         <= cmd_b;
            op_q        <= cmd_op;
            last_q      <= last_d;
            cflg_q      <= cmd_flg;
            idx_q       <= 2'd0;
            zacc_q      <= 1'b1;
            res_word_q  <= '0;
            cmd_ready_q <= 1'b0;
            state_q     <= S_RUN;
          end
        end
        S_RUN: begin
          res_word_q[word_sel] <= keep_a ? a_q[word_sel] : alu_q;
          sflg_q               <= alu_flg;
          zacc_q               <= zacc_q & alu_flg[0];
          if (top_word) vs_q   <= {alu_flg[3], alu_flg[1]};
          if (last_step) begin
            res_flg_q   <= res_flg_d;
            res_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            idx_q       <= 2'd0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_chain_ctrl.sv
// Testbench for alu_chain_ctrl: word-level ALU model on the ALU side,
// full-width arithmetic reference model for the final result and flags.
module tb_alu_chain_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_len;
  logic [47:0] cmd_a;
  logic [47:0] cmd_b;
  logic [4:0]  cmd_flg;
  logic [11:0] alu_a;
  logic [11:0] alu_b;
  logic [4:0]  alu_op;
  logic [4:0]  alu_flg_in;
  logic [11:0] alu_q;
  logic [4:0]  alu_flg;
  logic        res_valid;
  logic        res_ready;
  logic [47:0] res_q;
  logic [4:0]  res_flg;

  int n_checks = 0;
  int n_pass   = 0;

  alu_chain_ctrl #(.WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_flg(cmd_flg),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_flg_in(alu_flg_in),
    .alu_q(alu_q), .alu_flg(alu_flg),
    .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q), .res_flg(res_flg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 12-bit ALU: returns {P,V,K,S,Z, q}
  function automatic logic [16:0] alu_f(input logic [4:0] op, input logic [11:0] a,
                                        input logic [11:0] b, input logic [4:0] fin);
    logic [12:0] t;
    logic [11:0] q;
    logic k, v;
    q = b; k = fin[2]; v = fin[3]; t = 13'd0;
    case (op)
      5'h04, 5'h05: begin
        t = {1'b0, a} + {1'b0, b} + ((op == 5'h05) ? {12'd0, fin[2]} : 13'd0);
        q = t[11:0]; k = t[12]; v = (a[11] == b[11]) && (q[11] != a[11]);
      end
      5'h06, 5'h07: begin
        t = {1'b0, a} - {1'b0, b} - ((op == 5'h07) ? {12'd0, fin[2]} : 13'd0);
        q = t[11:0]; k = t[12]; v = (a[11] != b[11]) && (q[11] != a[11]);
      end
      5'h0C: begin q = {a[10:0], 1'b0};    k = a[11]; v = q[11] ^ a[11]; end
      5'h0A: begin q = {a[10:0], fin[2]};  k = a[11]; v = q[11] ^ a[11]; end
      5'h0D: begin q = {1'b0, a[11:1]};    k = a[0];  v = q[11] ^ a[11]; end
      5'h0B: begin q = {fin[2], a[11:1]};  k = a[0];  v = q[11] ^ a[11]; end
      5'h0F: begin q = {a[11], a[11:1]};   k = a[0];  v = 1'b0; end
      default: begin q = b; end
    endcase
    return {^q, v, k, q[11], (q == 12'h000), q};
  endfunction

  always_comb {alu_flg, alu_q} = alu_f(alu_op, alu_a, alu_b, alu_flg_in);

  // Full-width reference: returns {flags, result}
  function automatic logic [52:0] ref_fn(input logic [2:0] op, input int n, input logic [47:0] a,
                                         input logic [47:0] b, input logic [4:0] flg);
    logic [63:0] m, am, bm, r, s;
    logic k, v, is_cmp;
    int msb;
    m = (64'd1 << (12 * n)) - 64'd1;
    am = {16'd0, a} & m; bm = {16'd0, b} & m; msb = 12 * n - 1;
    r = 64'd0; k = 1'b0; v = 1'b0; is_cmp = 1'b0;
`ifdef ALU_CHAIN_CMP_EN
    is_cmp = (op == 3'd5);
`endif
    if (op == 3'd0) begin
      s = am + bm; r = s & m; k = s[12 * n];
      v = (am[msb] == bm[msb]) && (r[msb] != am[msb]);
    end else if (op == 3'd1 || is_cmp) begin
      r = (am - bm) & m; k = (am < bm);
      v = (am[msb] != bm[msb]) && (r[msb] != am[msb]);
    end else if (op == 3'd2) begin
      r = (am << 1) & m; k = am[msb]; v = r[msb] ^ am[msb];
    end else if (op == 3'd3) begin
      r = am >> 1; k = am[0]; v = am[msb];
    end else if (op == 3'd4) begin
      r = (am >> 1) | ({63'd0, am[msb]} << msb); k = am[0]; v = 1'b0;
    end else begin
      return {flg, am[47:0]};
    end
    if (is_cmp) return {flg[4], v, k, r[msb], (r == 64'd0), am[47:0]};
    return {flg[4], v, k, r[msb], (r == 64'd0), r[47:0]};
  endfunction

  function automatic logic [4:0] exp_op(input logic [2:0] op, input bit first);
    case (op)
      3'd0: return first ? 5'h04 : 5'h05;
      3'd1: return first ? 5'h06 : 5'h07;
      3'd2: return first ? 5'h0C : 5'h0A;
      3'd3: return first ? 5'h0D : 5'h0B;
      3'd4: return first ? 5'h0F : 5'h0B;
`ifdef ALU_CHAIN_CMP_EN
      3'd5: return first ? 5'h06 : 5'h07;
`endif
      default: return 5'h00;
    endcase
  endfunction

  // One full command: accept, n RUN steps, optional backpressure, handshake
  task automatic run_cmd(input logic [2:0] op, input logic [1:0] len, input logic [47:0] a,
                         input logic [47:0] b, input logic [4:0] flg, input int hold);
    int n, w;
    logic [52:0] e;
    logic [11:0] ea, eb;
    bit uses_b;
    n = int'(len) + 1;
    e = ref_fn(op, n, a, b, flg);
    uses_b = (op == 3'd0) || (op == 3'd1);
`ifdef ALU_CHAIN_CMP_EN
    if (op == 3'd5) uses_b = 1'b1;
`endif
    cmd_op = op; cmd_len = len; cmd_a = a; cmd_b = b; cmd_flg = flg; cmd_valid = 1'b1;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL accept_ready op=%0d got=%b want=1", op, cmd_ready);
    else n_pass++;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      w  = (op == 3'd3 || op == 3'd4) ? (n - 1 - i) : i;
      ea = a[12 * w +: 12];
      eb = uses_b ? b[12 * w +: 12] : a[12 * w +: 12];
      n_checks++;
      if (alu_op !== exp_op(op, i == 0) || alu_a !== ea || alu_b !== eb || res_valid !== 1'b0)
        $display("FAIL step op=%0d i=%0d got op=%h a=%h b=%h v=%b want op=%h a=%h b=%h v=0",
                 op, i, alu_op, alu_a, alu_b, res_valid, exp_op(op, i == 0), ea, eb);
      else n_pass++;
      if (i == 0) begin
        n_checks++;
        if (alu_flg_in !== flg) $display("FAIL flg_in0 got=%h want=%h", alu_flg_in, flg);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (res_valid !== 1'b1) $display("FAIL latency op=%0d n=%0d res_valid got=%b want=1", op, n, res_valid);
    else n_pass++;
    for (int h = 0; h < hold; h++) begin
      n_checks++;
      if (res_q !== e[47:0] || res_flg !== e[52:48] || cmd_ready !== 1'b0 || res_valid !== 1'b1 ||
          alu_op !== 5'h00)
        $display("FAIL hold h=%0d got q=%h f=%h rdy=%b v=%b op=%h want q=%h f=%h rdy=0 v=1 op=00",
                 h, res_q, res_flg, cmd_ready, res_valid, alu_op, e[47:0], e[52:48]);
      else n_pass++;
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    n_checks++;
    if (res_q !== e[47:0] || res_flg !== e[52:48])
      $display("FAIL result op=%0d n=%0d a=%h b=%h got q=%h f=%h want q=%h f=%h",
               op, n, a, b, res_q, res_flg, e[47:0], e[52:48]);
    else n_pass++;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL release got v=%b rdy=%b want v=0 rdy=1", res_valid, cmd_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_checks++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || res_q !== 48'd0 || res_flg !== 5'd0 ||
        alu_op !== 5'h00 || alu_a !== 12'h000 || alu_flg_in !== 5'h00)
      $display("FAIL reset got rdy=%b v=%b q=%h f=%h op=%h", cmd_ready, res_valid, res_q, res_flg, alu_op);
    else n_pass++;
  endtask

  task automatic test_add();
    run_cmd(3'd0, 2'd1, 48'h000000_000FFF, 48'h000000_000001, 5'd0, 0);
    run_cmd(3'd0, 2'd3, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 5'd0, 0);
    run_cmd(3'd0, 2'd0, 48'h0000_0000_07FF, 48'h0000_0000_0001, 5'h1F, 0);
  endtask

  task automatic test_sub();
    run_cmd(3'd1, 2'd1, 48'h000000_000000, 48'h000000_000001, 5'd0, 0);
    run_cmd(3'd1, 2'd3, 48'h8000_0000_0000, 48'h0000_0000_0001, 5'h10, 0);
  endtask

  task automatic test_shift();
    run_cmd(3'd3, 2'd2, 48'h000_001000000, 48'd0, 5'd0, 0);
    run_cmd(3'd4, 2'd1, 48'h0000_0080_0001, 48'd0, 5'd0, 0);
    run_cmd(3'd2, 2'd2, 48'h000_C00800001, 48'd0, 5'h04, 0);
  endtask

  task automatic test_reserved();
    run_cmd(3'd5, 2'd2, 48'h1234_5678_9ABC, 48'h0000_0000_0FFF, 5'h0B, 0);
    run_cmd(3'd6, 2'd3, 48'hFEDC_BA98_7654, 48'h0, 5'h15, 0);
    run_cmd(3'd7, 2'd0, 48'h0000_0000_0000, 48'h0, 5'h1F, 0);
  endtask

  task automatic test_backpressure();
    run_cmd(3'd0, 2'd2, 48'h000_123456789, 48'h000_FEDCBA987, 5'h00, 5);
  endtask

  task automatic test_back_to_back();
    run_cmd(3'd1, 2'd0, 48'h5, 48'h7, 5'd0, 0);
    run_cmd(3'd0, 2'd1, 48'h000_800_800, 48'h000_800_800, 5'd0, 0);
  endtask

  task automatic test_random();
    logic [47:0] a, b;
    for (int t = 0; t < 40; t++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      run_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), a, b,
              5'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_reset_mid_run();
    cmd_op = 3'd0; cmd_len = 2'd3; cmd_a = 48'hFFFF_FFFF_FFFF; cmd_b = 48'h1; cmd_flg = 5'd0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (alu_op !== 5'h05) $display("FAIL midrun_step1 got op=%h want=05", alu_op);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || res_q !== 48'd0 || alu_op !== 5'h00 || cmd_ready !== 1'b1)
      $display("FAIL midrun_reset got v=%b q=%h op=%h rdy=%b want v=0 q=0 op=00 rdy=1",
               res_valid, res_q, alu_op, cmd_ready);
    else n_pass++;
    run_cmd(3'd0, 2'd3, 48'hFFFF_FFFF_FFFF, 48'h1, 5'd0, 1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_len = 2'd0;
    cmd_a = 48'd0; cmd_b = 48'd0; cmd_flg = 5'd0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_reserved();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
